// File: rtl/ar_tdm_demux4.sv
// ar_tdm_demux4: registered 1:4 time-division demultiplexer with frame sync.
// Every four accepted beats (slot 0..3, slot 0 flagged by 'frame') are collected
// and presented together on 'y' with a one-cycle 'y_valid' strobe.
module ar_tdm_demux4 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [WIDTH-1:0]   din,
  input  logic               din_valid,
  input  logic               frame,
  output logic [4*WIDTH-1:0] y,
  output logic               y_valid,
  output logic               locked,
  output logic               sync_err
);

  typedef enum logic [0:0] {StHunt, StSync} state_e;

  state_e                  state_q, state_d;
  logic [1:0]              slot_q, slot_d;
  // Slots 0..2 are staged; slot 3 goes straight to y with the staged words.
  logic [2:0][WIDTH-1:0]   stg_q, stg_d;
  logic [4*WIDTH-1:0]      y_q, y_d;
  logic                    y_valid_q, y_valid_d;
  logic                    locked_q, locked_d;
  logic                    sync_err_q, sync_err_d;

  // Next-state: frame tracking, staging and output updates for one beat.
  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    stg_d      = stg_q;
    y_d        = y_q;
    y_valid_d  = 1'b0;
    sync_err_d = 1'b0;

    if (!enable) begin
      state_d = StHunt;
      slot_d  = 2'd0;
      y_d     = '0;
    end else if (din_valid) begin
      case (state_q)
        StHunt: begin
          // Non-marker beats are dropped silently until a marker is seen.
          if (frame) begin
            stg_d[0] = din;
            slot_d   = 2'd1;
            state_d  = StSync;
          end
        end
        StSync: begin
          if (frame) begin
            // Early marker abandons the partial frame and restarts at slot 0.
            if (slot_q != 2'd0) sync_err_d = 1'b1;
            stg_d[0] = din;
            slot_d   = 2'd1;
          end else if (slot_q == 2'd0) begin
            // Missing marker: lose lock.
            sync_err_d = 1'b1;
            state_d    = StHunt;
            slot_d     = 2'd0;
          end else if (slot_q == 2'd3) begin
            y_d       = {din, stg_q[2], stg_q[1], stg_q[0]};
            y_valid_d = 1'b1;
            slot_d    = 2'd0;
          end else begin
            stg_d[slot_q] = din;
            slot_d        = slot_q + 2'd1;
          end
        end
        default: begin
          state_d = StHunt;
          slot_d  = 2'd0;
        end
      endcase
    end

    locked_d = (state_d == StSync);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StHunt;
      slot_q     <= 2'd0;
      stg_q      <= '0;
      y_q        <= '0;
      y_valid_q  <= 1'b0;
      locked_q   <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      stg_q      <= stg_d;
      y_q        <= y_d;
      y_valid_q  <= y_valid_d;
      locked_q   <= locked_d;
      sync_err_q <= sync_err_d;
    end
  end

  assign y        = y_q;
  assign y_valid  = y_valid_q;
  assign locked   = locked_q;
  assign sync_err = sync_err_q;

endmodule

// File: doc/ar_tdm_demux4.md
# ar_tdm_demux4

Registered time-division demultiplexer with frame synchronisation. It receives a stream of WIDTH-bit words in which every four consecutive beats form one frame (slot 0 to slot 3), with slot 0 flagged by a frame marker. It separates each frame into four channel words and presents all four together on a parallel output with a one-cycle valid strobe. It is the receive-side counterpart of the 4:1 channel multiplexers in the datapath: it rebuilds the per-channel words that a slot-sequenced 4:1 mux serialises.

## Interface
Parameters:
- WIDTH, 8, width of one channel word / one input beat (≥1)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- enable  input  1  block enable; low forces outputs to 0 and drops lock
- din  input  WIDTH  input word for the current slot
- din_valid  input  1  din/frame qualify this cycle (one beat)
- frame  input  1  marks the beat as slot 0; sampled only with din_valid
- y  output  4*WIDTH  demuxed frame; y[WIDTH*(k+1)-1 : WIDTH*k] = channel k (slot k)
- y_valid  output  1  one-cycle pulse: y holds a newly completed frame
- locked  output  1  high while in SYNC state
- sync_err  output  1  one-cycle pulse on a framing violation

## Operation
- Reset (rst=1 at edge) sets the state to HUNT, slot counter to 0, staging registers to 0, y to 0, y_valid to 0, locked to 0, and sync_err to 0. rst has priority over enable.
- enable=0 at an edge:
  - state goes to HUNT and the slot counter to 0;
  - y is cleared to 0, and y_valid and sync_err are 0;
  - beats are ignored.
- When enable returns to 1, the block resumes hunting with no extra delay.
- Beats are accepted only when din_valid=1. Cycles with din_valid=0 change nothing (gaps are allowed anywhere in a frame), and y_valid and sync_err are 0 in those cycles.
- HUNT state:
  - frame=0 beats are discarded silently, with no sync_err.
  - A frame=1 beat stores din in staging[0], sets slot=1 and moves to SYNC.
- SYNC state, frame=0 beat, slot∈{1,2}: store din in staging[slot] and increment slot.
- SYNC state, frame=0 beat, slot=3:
  - y <= {din, staging[2], staging[1], staging[0]};
  - y_valid pulses;
  - slot wraps to 0.
- SYNC state, frame=1 beat, slot=0 (expected marker): store din in staging[0] and set slot=1.
- SYNC state, frame=1 beat, slot∈{1,2,3} (early marker):
  - sync_err pulses;
  - the partial frame is discarded and y is unchanged;
  - the beat is taken as a new slot 0 (staging[0]<=din, slot=1);
  - state stays SYNC.
- SYNC state, frame=0 beat, slot=0 (missing marker):
  - sync_err pulses;
  - the beat is discarded;
  - state goes to HUNT and slot to 0.
- locked = (state==SYNC), registered.
- y holds its last completed frame until the next completion, an enable drop, or reset.
- Staging registers are never visible on y except through a completed frame.

## Timing
- Latency: the edge that samples the slot-3 beat updates y and raises y_valid. Both are visible in the following cycle, and y_valid stays high for exactly that one cycle.
- Throughput: one beat per cycle sustained. Back-to-back frames give a y_valid pulse every 4th cycle.
- sync_err and the locked transitions are visible in the cycle after the offending beat's edge.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset/idle: assert rst for 2 cycles with random inputs → y=0, y_valid=0, locked=0, sync_err=0 throughout and in the first cycle after release.
- Lock and demux (WIDTH=8):
  - Stimulus: junk beats with frame=0, then beats 0x11(frame=1), 0x22, 0x33, 0x44 back-to-back.
  - Required response: junk causes no sync_err; locked=1 after 0x11; y=0x44332211 with a single y_valid pulse the cycle after 0x44.
- Gaps and streaming:
  - Stimulus: a frame 0xA0..0xA3 with din_valid=0 gaps inserted between slots, followed immediately by frame 0xB0..0xB3.
  - Required response: y=0xA3A2A1A0, then y=0xB3B2B1B0; exactly two y_valid pulses; y is stable between the pulses.
- Early marker:
  - Stimulus: while locked, 0x01(f), 0x02, then 0x03 with frame=1, then 0x04, 0x05, 0x06.
  - Required response: sync_err pulse after the 0x03 beat; locked stays 1; next y=0x06050403; no y_valid for the broken frame.
- Missing marker:
  - Stimulus: a complete frame, then a frame=0 beat at slot 0.
  - Required response: sync_err pulse and locked=0; subsequent frame=0 beats are ignored until a frame=1 beat relocks.
- Enable drop mid-frame:
  - Stimulus: after slots 0–1 are accepted, hold enable=0 for 1 cycle, then send slots 2–3 with frame=0.
  - Required response: y=0 and locked=0 after the drop; the later beats are discarded in HUNT; no y_valid and no sync_err.
